// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: synchronizes and debounces two raw push-button requests and turns
// them into mutually exclusive, fixed-width active-low set/reset pulses for an SR latch.

module sr_drive_ctrl_chk (
    input logic clk,
    input logic rst_n,
    input logic s_n,
    input logic r_n,
    input logic busy,
    input logic conflict
);
    // The latch must never see both inputs low
    a_never_both_low: assert property (@(posedge clk) disable iff (!rst_n)
        (s_n || r_n));

    a_pulse_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        ((s_n && r_n) || busy));

    a_conflict_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (!conflict || (!busy && s_n && r_n)));
endmodule

module sr_drive_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 3,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic conflict,
    output logic q_shadow
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);

    // Bit 0 carries the set request path, bit 1 the reset request path.
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       deb_r;
    logic [1:0]       deb_d_r;
    logic [1:0]       pend_r;
    logic [1:0]       ev_s;
    logic [1:0]       want_s;
    logic [CNT_W-1:0] deb_cnt_r [2];
    logic [CNT_W-1:0] pcnt_r;
    state_t           state_r;

    // Next state out of IDLE/GAP: a lone request is served, both together are dropped.
    function automatic state_t dispatch(input logic [1:0] want);
        case (want)
            2'b01:   dispatch = SET_P;
            2'b10:   dispatch = RST_P;
            default: dispatch = IDLE;
        endcase
    endfunction

    // Rising edges of the debounced levels and everything awaiting service
    always_comb begin
        ev_s   = deb_r & ~deb_d_r;
        want_s = pend_r | ev_s;
    end

    // Two-flop synchronizers for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {rst_req, set_req};
            sync2_r <= sync1_r;
        end
    end

    // Per-input debounce: the level follows sync2 only after a long enough mismatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r        <= 2'b00;
            deb_d_r      <= 2'b00;
            deb_cnt_r[0] <= CNT_ZERO;
            deb_cnt_r[1] <= CNT_ZERO;
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= CNT_ZERO;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + CNT_ONE;
                    end
                end else begin
                    deb_cnt_r[i] <= CNT_ZERO;
                end
            end
        end
    end

    // Pulse sequencer with pending-request bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pend_r   <= 2'b00;
            pcnt_r   <= CNT_ZERO;
            s_n      <= 1'b1;
            r_n      <= 1'b1;
            busy     <= 1'b0;
            conflict <= 1'b0;
            q_shadow <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state_r)
                // GAP already holds both outputs high, so it may launch the next pulse
                IDLE, GAP: begin
                    state_r  <= dispatch(want_s);
                    pend_r   <= 2'b00;
                    pcnt_r   <= CNT_ZERO;
                    s_n      <= ~(want_s == 2'b01);
                    r_n      <= ~(want_s == 2'b10);
                    busy     <= (want_s == 2'b01) || (want_s == 2'b10);
                    conflict <= (want_s == 2'b11);
                end
                SET_P, RST_P: begin
                    pend_r <= want_s;
                    if (pcnt_r == PULSE_LAST) begin
                        state_r  <= GAP;
                        s_n      <= 1'b1;
                        r_n      <= 1'b1;
                        q_shadow <= (state_r == SET_P);
                    end else begin
                        pcnt_r <= pcnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pend_r  <= 2'b00;
                    pcnt_r  <= CNT_ZERO;
                    s_n     <= 1'b1;
                    r_n     <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    sr_drive_ctrl_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_n      (s_n),
        .r_n      (r_n),
        .busy     (busy),
        .conflict (conflict)
    );
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: window-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.

module tb_sr_drive_ctrl;
    localparam int DEB = 4;
    localparam int PW  = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
    logic s_n, r_n, busy, conflict, q_shadow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sr_drive_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_WIDTH     (PW),
        .CNT_W           (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .rst_req  (rst_req),
        .s_n      (s_n),
        .r_n      (r_n),
        .busy     (busy),
        .conflict (conflict),
        .q_shadow (q_shadow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 set pulse, 2 reset pulse, 3 gap
    logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_deb = 2'b00, m_debd = 2'b00, m_pend = 2'b00;
    bit         hist [2][DEB];
    int         hcnt [2];
    int         m_mode = 0;
    int         m_left = 0;
    logic       m_q    = 1'b0;
    logic       m_conf = 1'b0;

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_deb = 2'b00; m_debd = 2'b00; m_pend = 2'b00;
        for (int i = 0; i < 2; i++) begin
            hcnt[i] = 0;
            for (int k = 0; k < DEB; k++) hist[i][k] = 1'b0;
        end
        m_mode = 0; m_left = 0; m_q = 1'b0; m_conf = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] want;
        logic [1:0] new_deb;
        logic [1:0] in_v;
        bit         differ;
        in_v = {rst_req, set_req};
        want = m_pend | (m_deb & ~m_debd);
        m_conf = 1'b0;
        if (m_mode == 0 || m_mode == 3) begin
            if (want == 2'b11) begin
                m_conf = 1'b1; want = 2'b00; m_mode = 0;
            end else if (want[0]) begin
                m_mode = 1; m_left = PW - 1; want = 2'b00;
            end else if (want[1]) begin
                m_mode = 2; m_left = PW - 1; want = 2'b00;
            end else begin
                m_mode = 0;
            end
        end else begin
            if (m_left == 0) begin
                m_q = (m_mode == 1); m_mode = 3;
            end else begin
                m_left--;
            end
        end
        m_pend = want;
        // debounced level flips once the last DEB synchronized samples all disagree with it
        new_deb = m_deb;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEB - 1; k++) hist[i][k] = hist[i][k+1];
            hist[i][DEB-1] = m_s2[i];
            if (hcnt[i] < DEB) hcnt[i]++;
            differ = (hcnt[i] == DEB);
            for (int k = 0; k < DEB; k++) if (hist[i][k] == m_deb[i]) differ = 1'b0;
            if (differ) new_deb[i] = ~m_deb[i];
        end
        m_debd = m_deb;
        m_deb  = new_deb;
        m_s2   = m_s1;
        m_s1   = in_v;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int low_s = 0;
    int low_r = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                low_s = 0;
                low_r = 0;
            end else begin
                chk("model s_n", s_n, m_mode != 1);
                chk("model r_n", r_n, m_mode != 2);
                chk("model busy", busy, m_mode != 0);
                chk("model conflict", conflict, m_conf);
                chk("model q_shadow", q_shadow, m_q);
                chk("never_both_low", s_n | r_n, 1'b1);
                if (!s_n) low_s++;
                else if (low_s > 0) begin chk_int("s_n pulse width", low_s, PW); low_s = 0; end
                if (!r_n) low_r++;
                else if (low_r > 0) begin chk_int("r_n pulse width", low_r, PW); low_r = 0; end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic pin_set(input logic q_before);
        int e0;
        @(negedge clk);
        set_req = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("pin_set s_n", s_n, !(cyc >= e0 + 6 && cyc <= e0 + 8));
            chk("pin_set r_n", r_n, 1'b1);
            chk("pin_set busy", busy, (cyc >= e0 + 6 && cyc <= e0 + 9));
            chk("pin_set q_shadow", q_shadow, (cyc >= e0 + 9) ? 1'b1 : q_before);
        end
        set_req = 1'b0;
        tick(12);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        int e0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset s_n", s_n, 1'b1);
        chk("reset r_n", r_n, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset conflict", conflict, 1'b0);
        chk("reset q_shadow", q_shadow, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // basic set pulse
        pin_set(1'b0);

        // bounce rejection: 2 high, 2 low, 2 high, then low
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            set_req = (k < 2) || (k >= 4 && k < 6);
            chk("bounce s_n", s_n, 1'b1);
            chk("bounce busy", busy, 1'b0);
            chk("bounce q_shadow", q_shadow, 1'b1);
        end
        set_req = 1'b0;
        tick(4);

        // simultaneous requests are discarded with a single conflict pulse
        @(negedge clk);
        set_req = 1'b1;
        rst_req = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("simul conflict", conflict, cyc == e0 + 6);
            chk("simul s_n", s_n, 1'b1);
            chk("simul r_n", r_n, 1'b1);
            chk("simul q_shadow", q_shadow, 1'b1);
        end
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(12);

        // asynchronous reset in the middle of a set pulse
        @(negedge clk);
        set_req = 1'b1;
        e0 = cyc + 1;
        while (cyc < e0 + 7) @(negedge clk);
        chk("midreset s_n before", s_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset s_n", s_n, 1'b1);
        chk("midreset r_n", r_n, 1'b1);
        chk("midreset busy", busy, 1'b0);
        chk("midreset q_shadow", q_shadow, 1'b0);
        set_req = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        pin_set(1'b0);

        // reset request queued during a set pulse
        @(negedge clk);
        set_req = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        rst_req = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("queued s_n", s_n, !(cyc >= e0 + 6 && cyc <= e0 + 8));
            chk("queued r_n", r_n, !(cyc >= e0 + 10 && cyc <= e0 + 12));
            chk("queued busy", busy, (cyc >= e0 + 6 && cyc <= e0 + 13));
            chk("queued q_shadow", q_shadow, (cyc >= e0 + 13) ? 1'b0 : 1'b1);
        end
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(12);

        // random toggling of both buttons
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) set_req = ~set_req;
            if ($urandom_range(0, 5) == 0) rst_req = ~rst_req;
        end
        set_req = 1'b0;
        rst_req = 1'b0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_drive_ctrl.md
# sr_drive_ctrl

Front-end controller that sits directly upstream of the cross-coupled SR latch and drives its active-low set/reset inputs. Two raw, asynchronous push-button requests are synchronized, debounced and converted into clean, fixed-width, mutually exclusive active-low pulses. The latch therefore never sees the forbidden both-low input combination. A registered shadow of the expected latch state is kept for checking.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a debounced level changes (≥1)
- PULSE_WIDTH, 3: cycles that s_n or r_n is held low per accepted request (≥1)
- CNT_W, 8: width of the debounce and pulse counters; must hold max(DEBOUNCE_CYCLES, PULSE_WIDTH)
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- set_req  input  1  raw set button, active-high, asynchronous to clk
- rst_req  input  1  raw reset button, active-high, asynchronous to clk
- s_n  output  1  active-low set to the latch
- r_n  output  1  active-low reset to the latch
- busy  output  1  high whenever the FSM is not in IDLE
- conflict  output  1  one-cycle pulse when simultaneous set and reset requests are discarded
- q_shadow  output  1  expected latch Q after the last completed pulse

## Operation
- Each raw input passes through a 2-flop synchronizer (sync1, sync2).
- Debounce runs per input with one counter and a deb level.
  - If sync2 ≠ deb, cnt increments. When the mismatch persists with cnt == DEBOUNCE_CYCLES−1, deb ← sync2 and cnt ← 0.
  - If sync2 == deb, cnt ← 0.
- A request event is a rising edge of deb (deb & ~deb_d). Falling edges generate nothing.
- Each input has a pending flag. It is set by its event and cleared when that event is served or discarded.
- FSM states are IDLE, SET_P, RST_P and GAP.
  - IDLE, both set and reset pending (or both events in the same cycle): conflict = 1 for one cycle, both pending flags cleared, stay in IDLE.
  - IDLE, set pending only: go to SET_P, s_n ← 0, pulse counter ← 0.
  - IDLE, reset pending only: go to RST_P, r_n ← 0, pulse counter ← 0.
  - SET_P / RST_P: hold the pulse for PULSE_WIDTH cycles. Then the active output returns to 1, q_shadow ← 1 (SET_P) or 0 (RST_P), and the FSM goes to GAP.
  - GAP: one cycle with s_n = r_n = 1, then IDLE.
- Events arriving while busy only set pending flags. They are evaluated on return to IDLE, with the same conflict rule.
- Invariant: s_n and r_n are never both 0 in any cycle.
- All outputs are registered.

## Timing
- Reset values: s_n = 1, r_n = 1, busy = 0, conflict = 0, q_shadow = 0. Synchronizers, deb, counters and pending flags are all 0, and state is IDLE.
- Reset is asynchronous. Asserting rst_n mid-pulse forces s_n/r_n high immediately, and any pending requests are lost.
- Latency: let E0 be the first edge sampling a set_req held stably high. Then sync2 = 1 after E0+1, deb = 1 after E0+1+DEBOUNCE_CYCLES, and s_n falls at E0+2+DEBOUNCE_CYCLES.
- Pulse: s_n is low for exactly PULSE_WIDTH cycles. q_shadow updates on the edge where s_n returns high.
- busy rises on the same edge s_n/r_n falls, and falls one cycle after the pulse ends (after GAP).
- Minimum spacing between consecutive pulses is one high cycle (GAP).
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.

## Test plan
- **Basic set:** DEBOUNCE_CYCLES = 4, PULSE_WIDTH = 3; release reset, then hold set_req high from E0.
  - Expect s_n low on edges E0+6 to E0+8 (3 cycles) and q_shadow = 1 after the pulse.
  - Expect r_n = 1 throughout and busy high for 4 cycles.
- **Bounce rejection:** set_req high for 2 clk cycles, low for 2, high for 2, then low.
  - Expect s_n never low and no state change.
- **Simultaneous requests:** raise set_req and rst_req on the same edge and hold both.
  - Expect conflict = 1 for exactly one cycle, s_n = r_n = 1 throughout, and q_shadow unchanged.
- **Queued request:** trigger a set; during SET_P, produce a debounced rst_req event.
  - Expect the set pulse (3 cycles), one GAP cycle, then r_n low for 3 cycles, with q_shadow going 1 then 0.
- **Reset mid-operation:** assert rst_n while s_n is low.
  - Expect s_n = 1, busy = 0 and q_shadow = 0 immediately, without waiting for a clk edge.
  - After release, a new set request produces a normal pulse.
- **Invariant monitor:** run random toggling of both inputs for 10,000 cycles.
  - Expect s_n | r_n == 1 on every cycle, and every low pulse exactly 3 cycles wide.
